// File: rtl/safelock_pkg.sv
// Shared types and constants for the safelock password path (getter and checker).
package safelock_pkg;

    localparam int PW_W = 12;

    localparam logic [PW_W-1:0] DFLT_PW             = 12'h123;
    localparam int              DFLT_MAX_FAILS      = 3;
    localparam int              DFLT_LOCKOUT_CYCLES = 1000;
    localparam int              DFLT_UNLOCK_CYCLES  = 500;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } state_e;

    // Larger of two integers; used to size the shared period timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/safelock_if.sv
// Password-check handshake between the keypad side (master) and the checker (slave).
interface safelock_if;
    import safelock_pkg::*;

    logic [PW_W-1:0] i_password;
    logic            i_enter;
    logic            i_lock;
    logic            i_set;
    logic            o_unlocked;
    logic            o_alarm;
    logic [1:0]      o_fail_count;
    logic            o_clear_entry;

    modport master (
        output i_password, i_enter, i_lock, i_set,
        input  o_unlocked, o_alarm, o_fail_count, o_clear_entry
    );

    modport slave (
        input  i_password, i_enter, i_lock, i_set,
        output o_unlocked, o_alarm, o_fail_count, o_clear_entry
    );

endinterface

// File: rtl/safelock_timer.sv
// Loadable down-counter shared by the unlock and lockout periods.
// It saturates at zero; the owning FSM decides what happens when it gets there.
module safelock_timer #(
    parameter int WIDTH = 10
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec_en,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load wins over decrement, decrement holds at zero.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec_en && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/safelock_checker.sv
// Password verification controller: compares the getter's entry with the stored
// code, drives unlock, counts consecutive failures, enforces a timed lockout with
// alarm, auto-relocks, and allows the code to be changed while open.
module safelock_checker
    import safelock_pkg::*;
#(
    parameter logic [PW_W-1:0] DEFAULT_PW     = DFLT_PW,
    parameter int              MAX_FAILS      = DFLT_MAX_FAILS,
    parameter int              LOCKOUT_CYCLES = DFLT_LOCKOUT_CYCLES,
    parameter int              UNLOCK_CYCLES  = DFLT_UNLOCK_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    safelock_if.slave  bus
);

    localparam int              TMR_W        = $clog2(max_int(LOCKOUT_CYCLES, UNLOCK_CYCLES));
    localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]      MAX_FAILS_W  = 3'(MAX_FAILS);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [PW_W-1:0]   code_r;
    logic [PW_W-1:0]   code_nxt_s;
    logic [PW_W-1:0]   entry_r;
    logic [PW_W-1:0]   entry_nxt_s;
    logic [1:0]        fail_cnt_r;
    logic [1:0]        fail_nxt_s;
    logic [2:0]        fail_inc_s;
    logic              clear_nxt_s;
    logic              unlocked_r;
    logic              alarm_r;
    logic              clear_r;
    logic              tmr_load_s;
    logic [TMR_W-1:0]  tmr_load_val_s;
    logic              tmr_dec_s;
    logic              tmr_zero_s;

    // One extra bit so the compare against MAX_FAILS cannot overflow.
    assign fail_inc_s = {1'b0, fail_cnt_r} + 3'd1;

    safelock_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .load       (tmr_load_s),
        .load_value (tmr_load_val_s),
        .dec_en     (tmr_dec_s),
        .zero       (tmr_zero_s)
    );

    // State, code, entry, fail count and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r    <= LOCKED;
            code_r     <= DEFAULT_PW;
            entry_r    <= {PW_W{1'b0}};
            fail_cnt_r <= 2'd0;
            unlocked_r <= 1'b0;
            alarm_r    <= 1'b0;
            clear_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            code_r     <= code_nxt_s;
            entry_r    <= entry_nxt_s;
            fail_cnt_r <= fail_nxt_s;
            unlocked_r <= (state_nxt_s == UNLOCKED);
            alarm_r    <= (state_nxt_s == LOCKOUT);
            clear_r    <= clear_nxt_s;
        end
    end

    // Next-state logic, register updates and timer control.
    always_comb begin
        state_nxt_s    = state_r;
        code_nxt_s     = code_r;
        entry_nxt_s    = entry_r;
        fail_nxt_s     = fail_cnt_r;
        clear_nxt_s    = 1'b0;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = {TMR_W{1'b0}};
        tmr_dec_s      = 1'b0;

        case (state_r)
            LOCKED: begin
                if (bus.i_enter) begin
                    entry_nxt_s = bus.i_password;
                    state_nxt_s = CHECK;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end

            CHECK: begin
                // The getter's entry is wiped whatever the outcome.
                clear_nxt_s = 1'b1;
                if (entry_r == code_r) begin
                    fail_nxt_s     = 2'd0;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = UNLOCK_LOAD;
                    state_nxt_s    = UNLOCKED;
                end else if (fail_inc_s < MAX_FAILS_W) begin
                    fail_nxt_s  = fail_inc_s[1:0];
                    state_nxt_s = LOCKED;
                end else begin
                    fail_nxt_s     = MAX_FAILS_W[1:0];
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = LOCKOUT_LOAD;
                    state_nxt_s    = LOCKOUT;
                end
            end

            UNLOCKED: begin
                if (bus.i_set) begin
                    code_nxt_s  = bus.i_password;
                    clear_nxt_s = 1'b1;
                    state_nxt_s = LOCKED;
                end else if (bus.i_lock) begin
                    state_nxt_s = LOCKED;
                end else if (tmr_zero_s) begin
                    state_nxt_s = LOCKED;
                end else begin
                    tmr_dec_s   = 1'b1;
                    state_nxt_s = UNLOCKED;
                end
            end

            LOCKOUT: begin
                if (tmr_zero_s) begin
                    fail_nxt_s  = 2'd0;
                    state_nxt_s = LOCKED;
                end else begin
                    tmr_dec_s   = 1'b1;
                    state_nxt_s = LOCKOUT;
                end
            end

            default: begin
                state_nxt_s = LOCKED;
            end
        endcase
    end

    assign bus.o_unlocked    = unlocked_r;
    assign bus.o_alarm       = alarm_r;
    assign bus.o_fail_count  = fail_cnt_r;
    assign bus.o_clear_entry = clear_r;

endmodule

// File: tb/tb_safelock_checker.sv
// Directed bench for safelock_checker (MAX_FAILS=3, LOCKOUT_CYCLES=8, UNLOCK_CYCLES=6).
module tb_safelock_checker;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hi_cnt;
    int   clr_cnt;
    int   un_cnt;

    safelock_if bus ();

    safelock_checker #(
        .DEFAULT_PW     (12'h123),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (8),
        .UNLOCK_CYCLES  (6)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse i_enter for one edge; returns at the negedge after that edge.
    task automatic enter_pw(input logic [11:0] pw);
        bus.i_password = pw;
        bus.i_enter    = 1'b1;
        tick();
        bus.i_enter    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_unl"},   {31'd0, bus.o_unlocked},    32'd0);
        check({tag, "_alarm"}, {31'd0, bus.o_alarm},       32'd0);
        check({tag, "_fail"},  {30'd0, bus.o_fail_count},  32'd0);
        check({tag, "_clr"},   {31'd0, bus.o_clear_entry}, 32'd0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.i_password = 12'h000;
        bus.i_enter    = 1'b0;
        bus.i_lock     = 1'b0;
        bus.i_set      = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Correct code: 2-cycle latency, one clear pulse, open for 6 cycles.
        enter_pw(12'h123);
        check("lat1_unl", {31'd0, bus.o_unlocked}, 32'd0);
        hi_cnt  = 0;
        clr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) check("lat2_unl", {31'd0, bus.o_unlocked}, 32'd1);
            hi_cnt  += int'(bus.o_unlocked);
            clr_cnt += int'(bus.o_clear_entry);
        end
        check("unlock_len", hi_cnt, 32'd6);
        check("clear_once", clr_cnt, 32'd1);

        // Two mismatches then the right code.
        enter_pw(12'h456);
        tick();
        check("fail1", {30'd0, bus.o_fail_count}, 32'd1);
        check("fail1_clr", {31'd0, bus.o_clear_entry}, 32'd1);
        tick();
        enter_pw(12'h456);
        tick();
        check("fail2", {30'd0, bus.o_fail_count}, 32'd2);
        tick();
        enter_pw(12'h123);
        tick();
        check("recover_unl", {31'd0, bus.o_unlocked}, 32'd1);
        check("recover_fail", {30'd0, bus.o_fail_count}, 32'd0);
        bus.i_lock = 1'b1;
        tick();
        bus.i_lock = 1'b0;
        check("lock1_unl", {31'd0, bus.o_unlocked}, 32'd0);

        // Three mismatches: lockout with alarm for 8 cycles, enter ignored.
        for (int k = 0; k < 2; k++) begin
            enter_pw(12'h999);
            tick();
            tick();
        end
        enter_pw(12'h999);
        tick();
        check("lockout_alarm", {31'd0, bus.o_alarm}, 32'd1);
        check("lockout_fail", {30'd0, bus.o_fail_count}, 32'd3);
        hi_cnt = 1;
        un_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            bus.i_password = 12'h123;
            bus.i_enter    = (i == 2);
            tick();
            hi_cnt += int'(bus.o_alarm);
            un_cnt += int'(bus.o_unlocked);
        end
        bus.i_enter = 1'b0;
        check("alarm_len", hi_cnt, 32'd8);
        check("alarm_ignore_enter", un_cnt, 32'd0);
        check("after_lockout_fail", {30'd0, bus.o_fail_count}, 32'd0);

        // Change the code to 789 while open.
        enter_pw(12'h123);
        tick();
        check("pre_set_unl", {31'd0, bus.o_unlocked}, 32'd1);
        bus.i_password = 12'h789;
        bus.i_set      = 1'b1;
        tick();
        bus.i_set      = 1'b0;
        check("set_unl", {31'd0, bus.o_unlocked}, 32'd0);
        check("set_clr", {31'd0, bus.o_clear_entry}, 32'd1);
        enter_pw(12'h123);
        tick();
        check("old_code_unl", {31'd0, bus.o_unlocked}, 32'd0);
        check("old_code_fail", {30'd0, bus.o_fail_count}, 32'd1);
        tick();
        enter_pw(12'h789);
        tick();
        check("new_code_unl", {31'd0, bus.o_unlocked}, 32'd1);

        // i_set and i_lock together: set wins and the state relocks.
        bus.i_password = 12'hABC;
        bus.i_set      = 1'b1;
        bus.i_lock     = 1'b1;
        tick();
        bus.i_set      = 1'b0;
        bus.i_lock     = 1'b0;
        check("setlock_unl", {31'd0, bus.o_unlocked}, 32'd0);
        check("setlock_clr", {31'd0, bus.o_clear_entry}, 32'd1);
        enter_pw(12'hABC);
        tick();
        check("abc_unl", {31'd0, bus.o_unlocked}, 32'd1);
        bus.i_lock = 1'b1;
        tick();
        bus.i_lock = 1'b0;
        check("lock2_unl", {31'd0, bus.o_unlocked}, 32'd0);
        check("lock2_clr", {31'd0, bus.o_clear_entry}, 32'd0);

        // Reset during lockout.
        for (int k = 0; k < 2; k++) begin
            enter_pw(12'h999);
            tick();
            tick();
        end
        enter_pw(12'h999);
        tick();
        check("rst_lo_alarm_pre", {31'd0, bus.o_alarm}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_lockout");
        rst_n = 1'b1;
        enter_pw(12'h123);
        tick();
        check("dflt_code_unl", {31'd0, bus.o_unlocked}, 32'd1);

        // Reset during unlocked restores the default code.
        bus.i_password = 12'h555;
        bus.i_set      = 1'b1;
        tick();
        bus.i_set      = 1'b0;
        tick();
        enter_pw(12'h555);
        tick();
        check("code555_unl", {31'd0, bus.o_unlocked}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_unlocked");
        rst_n = 1'b1;
        enter_pw(12'h123);
        tick();
        check("restored_code_unl", {31'd0, bus.o_unlocked}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
